if_fetch_stage: RTL and testbench

- Fetch stage plus IF/ID pipeline register for the P5 five-stage MIPS core.
- Owns the fetch PC and drives the instruction-memory request/ack handshake.
- Honours ID-stage redirects (branches and jumps, with one architectural delay slot) and hazard-unit stalls.
- Presents the ID-stage instruction word that the decoder consumes, plus PC and PC+8 (PC+8 is the jal/jalr/bgezal link value).

---
 rtl/if_fetch_stage_if.sv | 21 ++
 rtl/if_fetch_stage.sv | 170 +++++++++++++++++
 tb/tb_if_fetch_stage.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/ack bundle between the fetch stage (master) and the memory (slave).
interface if_fetch_stage_if;
    logic        im_req;
    logic [31:0] im_addr;
    logic        im_ack;
    logic [31:0] im_rdata;

    modport master (
        output im_req,
        output im_addr,
        input  im_ack,
        input  im_rdata
    );

    modport slave (
        input  im_req,
        input  im_addr,
        output im_ack,
        output im_rdata
    );
endinterface

// File: rtl/if_fetch_stage.sv
// Fetch stage and IF/ID register of the P5 MIPS core: PC, imem handshake, delayed redirects, stalls.
// Optional macro IF_FETCH_ADEL_EN flags misaligned redirect targets as fetch address errors.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             npc_valid,
    input  logic [31:0]      npc,
    if_fetch_stage_if.master imem,
    output logic [31:0]      instr_D,
    output logic [31:0]      pc_D,
    output logic [31:0]      pc8_D,
    output logic             valid_D,
    output logic             exc_adel_D
);

    typedef enum logic {
        REQ  = 1'b0,
        HOLD = 1'b1
    } fetchState_t;

    fetchState_t state_q, state_d;
    logic [31:0] pcF_q, pcF_d;
    logic        badF_q, badF_d;
    logic        pending_q, pending_d;
    logic [31:0] pendNpc_q, pendNpc_d;
    logic        pendBad_q, pendBad_d;
    logic [31:0] holdInstr_q, holdInstr_d;
    logic [31:0] holdPc_q, holdPc_d;
    logic        holdBad_q, holdBad_d;
    logic [31:0] instrD_q, instrD_d;
    logic [31:0] pcD_q, pcD_d;
    logic        validD_q, validD_d;
    logic        excD_q, excD_d;

    logic        advance;
    logic [31:0] npcAligned;
    logic        npcBad;
    logic [31:0] fetchWord;

    assign npcAligned = {npc[31:2], 2'b00};

`ifdef IF_FETCH_ADEL_EN
    assign npcBad     = |npc[1:0];
    assign exc_adel_D = excD_q;
`else
    logic unusedNpcLow;
    logic unusedExcD;
    assign npcBad       = 1'b0;
    assign unusedNpcLow = ^npc[1:0];
    assign unusedExcD   = excD_q;
    assign exc_adel_D   = 1'b0;
`endif

    // A fetch from a misaligned target never reaches the decoder as a real opcode.
    assign fetchWord = badF_q ? NOP_WORD : imem.im_rdata;

    assign imem.im_req  = reset && (state_q == REQ);
    assign imem.im_addr = pcF_q;

    assign instr_D = instrD_q;
    assign pc_D    = pcD_q;
    assign pc8_D   = pcD_q + 32'd8;
    assign valid_D = validD_q;

    always_comb begin
        state_d     = state_q;
        pcF_d       = pcF_q;
        badF_d      = badF_q;
        pending_d   = pending_q;
        pendNpc_d   = pendNpc_q;
        pendBad_d   = pendBad_q;
        holdInstr_d = holdInstr_q;
        holdPc_d    = holdPc_q;
        holdBad_d   = holdBad_q;
        instrD_d    = instrD_q;
        pcD_d       = pcD_q;
        validD_d    = validD_q;
        excD_d      = excD_q;
        advance     = 1'b0;

        case (state_q)
            REQ: begin
                if (imem.im_ack && !stall) begin
                    instrD_d = fetchWord;
                    pcD_d    = pcF_q;
                    validD_d = 1'b1;
                    excD_d   = badF_q;
                    advance  = 1'b1;
                end else if (imem.im_ack) begin
                    holdInstr_d = fetchWord;
                    holdPc_d    = pcF_q;
                    holdBad_d   = badF_q;
                    state_d     = HOLD;
                end else if (!stall) begin
                    instrD_d = NOP_WORD;
                    pcD_d    = pcF_q;
                    validD_d = 1'b0;
                    excD_d   = 1'b0;
                end
            end
            HOLD: begin
                if (!stall) begin
                    instrD_d = holdInstr_q;
                    pcD_d    = holdPc_q;
                    validD_d = 1'b1;
                    excD_d   = holdBad_q;
                    advance  = 1'b1;
                    state_d  = REQ;
                end
            end
            default: state_d = REQ;
        endcase

        // The delay slot is already in flight, so a redirect only takes effect on the next advance.
        if (advance) begin
            pending_d = 1'b0;
            if (npc_valid) begin
                pcF_d  = npcAligned;
                badF_d = npcBad;
            end else if (pending_q) begin
                pcF_d  = pendNpc_q;
                badF_d = pendBad_q;
            end else begin
                pcF_d  = pcF_q + 32'd4;
                badF_d = 1'b0;
            end
        end else if (npc_valid) begin
            pending_d = 1'b1;
            pendNpc_d = npcAligned;
            pendBad_d = npcBad;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= REQ;
            pcF_q       <= RESET_PC;
            badF_q      <= 1'b0;
            pending_q   <= 1'b0;
            pendNpc_q   <= 32'd0;
            pendBad_q   <= 1'b0;
            holdInstr_q <= NOP_WORD;
            holdPc_q    <= 32'd0;
            holdBad_q   <= 1'b0;
            instrD_q    <= NOP_WORD;
            pcD_q       <= 32'd0;
            validD_q    <= 1'b0;
            excD_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pcF_q       <= pcF_d;
            badF_q      <= badF_d;
            pending_q   <= pending_d;
            pendNpc_q   <= pendNpc_d;
            pendBad_q   <= pendBad_d;
            holdInstr_q <= holdInstr_d;
            holdPc_q    <= holdPc_d;
            holdBad_q   <= holdBad_d;
            instrD_q    <= instrD_d;
            pcD_q       <= pcD_d;
            validD_q    <= validD_d;
            excD_q      <= excD_d;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: directed plan then random traffic against a queue-based fetch model.
module tb_if_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;
`ifdef IF_FETCH_ADEL_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        exc;
    } idEntry_t;

    typedef struct packed {
        logic        chkId;
        logic        req;
        logic [31:0] addr;
        idEntry_t    id;
    } expect_t;

    typedef struct packed {
        logic [31:0] tgt;
        logic        bad;
    } redir_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        npc_valid;
    logic [31:0] npc;
    logic [31:0] instr_D;
    logic [31:0] pc_D;
    logic [31:0] pc8_D;
    logic        valid_D;
    logic        exc_adel_D;

    if_fetch_stage_if imem ();

    if_fetch_stage #(
        .RESET_PC(RESET_PC),
        .NOP_WORD(NOP_WORD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .stall     (stall),
        .npc_valid (npc_valid),
        .npc       (npc),
        .imem      (imem.master),
        .instr_D   (instr_D),
        .pc_D      (pc_D),
        .pc8_D     (pc8_D),
        .valid_D   (valid_D),
        .exc_adel_D(exc_adel_D)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    // The memory simply returns a hash of the requested address.
    assign imem.im_rdata = memWord(imem.im_addr);

    int checks = 0;
    int errors = 0;
    expect_t sbQ[$];
    bit firstCycle = 1'b1;

    // Reference model: next fetch address, an optional held word, and at most one waiting redirect.
    logic [31:0] mPc;
    bit          mPcBad;
    bit          mHeld;
    idEntry_t    mHeldEntry;
    idEntry_t    mId;
    redir_t      redirQ[$];

    function automatic idEntry_t fetchEntry();
        idEntry_t e;
        e.pc    = mPc;
        e.valid = 1'b1;
        e.exc   = mPcBad;
        e.instr = mPcBad ? NOP_WORD : memWord(mPc);
        return e;
    endfunction

    function automatic void modelStep(input logic r, input logic st, input logic ack,
                                      input logic nv, input logic [31:0] n);
        bit delivered;
        redir_t t;
        delivered = 1'b0;
        if (!r) begin
            mPc      = RESET_PC;
            mPcBad   = 1'b0;
            mHeld    = 1'b0;
            redirQ.delete();
            mId.instr = NOP_WORD;
            mId.pc    = 32'd0;
            mId.valid = 1'b0;
            mId.exc   = 1'b0;
            return;
        end
        if (!mHeld) begin
            if (ack && st) begin
                mHeld      = 1'b1;
                mHeldEntry = fetchEntry();
            end else if (ack) begin
                mId       = fetchEntry();
                delivered = 1'b1;
            end else if (!st) begin
                mId.instr = NOP_WORD;
                mId.pc    = mPc;
                mId.valid = 1'b0;
                mId.exc   = 1'b0;
            end
        end else if (!st) begin
            mId       = mHeldEntry;
            mHeld     = 1'b0;
            delivered = 1'b1;
        end
        t.tgt = {n[31:2], 2'b00};
        t.bad = ADEL && (n[1:0] != 2'b00);
        if (delivered) begin
            if (nv) begin
                mPc    = t.tgt;
                mPcBad = t.bad;
            end else if (redirQ.size() > 0) begin
                mPc    = redirQ[0].tgt;
                mPcBad = redirQ[0].bad;
            end else begin
                mPc    = mPc + 32'd4;
                mPcBad = 1'b0;
            end
            redirQ.delete();
        end else if (nv) begin
            redirQ.delete();
            redirQ.push_back(t);
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %08h expected %08h at %0t", name, got, want, $time);
        end
    endtask

    // Drive one cycle of inputs, queue what the DUT should show during it, then advance the model.
    task automatic applyStimulus(input logic r, input logic st, input logic ack,
                                 input logic nv, input logic [31:0] n);
        expect_t e;
        reset        = r;
        stall        = st;
        imem.im_ack  = ack;
        npc_valid    = nv;
        npc          = n;
        e.chkId      = !firstCycle;
        firstCycle   = 1'b0;
        e.req        = r && !mHeld;
        e.addr       = mPc;
        e.id         = mId;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        modelStep(r, st, ack, nv, n);
    endtask

    always @(negedge clk) begin
        expect_t e;
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("im_req", 32'(imem.im_req), 32'(e.req));
            if (e.req) checkOutput("im_addr", imem.im_addr, e.addr);
            if (e.chkId) begin
                checkOutput("instr_D", instr_D, e.id.instr);
                checkOutput("pc_D", pc_D, e.id.pc);
                checkOutput("pc8_D", pc8_D, e.id.pc + 32'd8);
                checkOutput("valid_D", 32'(valid_D), 32'(e.id.valid));
                checkOutput("exc_adel_D", 32'(exc_adel_D), 32'(e.id.exc));
            end
        end
    end

    initial begin
        logic r, st, ack, nv;
        logic [31:0] n;
        reset       = 1'b0;
        stall       = 1'b0;
        npc_valid   = 1'b0;
        npc         = 32'd0;
        imem.im_ack = 1'b0;
        mPc         = RESET_PC;
        mPcBad      = 1'b0;
        mHeld       = 1'b0;
        mHeldEntry  = '0;
        mId         = '0;
        @(posedge clk);
        #1;

        applyStimulus(0, 0, 0, 0, 32'd0);
        applyStimulus(0, 0, 0, 0, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(1, 0, 0, 0, 32'd0);
        applyStimulus(1, 0, 0, 0, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(1, 1, 1, 0, 32'd0);
        applyStimulus(1, 1, 0, 0, 32'd0);
        applyStimulus(1, 1, 1, 0, 32'd0);
        applyStimulus(1, 0, 0, 0, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(1, 0, 0, 1, 32'h0000_3100);
        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(1, 1, 1, 0, 32'd0);
        applyStimulus(1, 1, 0, 1, 32'h0000_3200);
        applyStimulus(0, 0, 1, 0, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(1, 0, 1, 1, 32'h0000_3102);
        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(1, 0, 1, 1, 32'hFFFF_FFFC);
        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'd0);
        applyStimulus(1, 0, 1, 0, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 99) != 0);
            st  = ($urandom_range(0, 3) == 0);
            ack = ($urandom_range(0, 9) < 7);
            nv  = ($urandom_range(0, 9) == 0);
            n   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            applyStimulus(r, st, ack, nv, n);
        end

        @(negedge clk);
        #1;
        checkOutput("sb_drain", 32'(sbQ.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
